// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared timing constants, standard modes and helpers for the raster timing generator
//
// Purpose: common definitions imported by the timing generator, its axis
// counters and the interface users.
//   POL_LOW / POL_HIGH  sync asserted level
//   axis_timing_t       one axis worth of active/porch/sync widths plus polarity
//   MODE_*              standard VESA/DMT modes, one horizontal and one vertical entry each
//   total()             sum of the four segment widths of an axis
package vga_timing_pkg;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } video_mode_t;

  // 640x480@60, 25.175 MHz pixel rate
  localparam video_mode_t MODE_640X480_60 = '{
    h: '{active: 640,  fp: 16, sync: 96,  bp: 48,  pol: POL_LOW},
    v: '{active: 480,  fp: 10, sync: 2,   bp: 33,  pol: POL_LOW}
  };

  // 800x600@60, 40 MHz pixel rate
  localparam video_mode_t MODE_800X600_60 = '{
    h: '{active: 800,  fp: 40, sync: 128, bp: 88,  pol: POL_HIGH},
    v: '{active: 600,  fp: 1,  sync: 4,   bp: 23,  pol: POL_HIGH}
  };

  // 1024x768@60, 65 MHz pixel rate
  localparam video_mode_t MODE_1024X768_60 = '{
    h: '{active: 1024, fp: 24, sync: 136, bp: 160, pol: POL_LOW},
    v: '{active: 768,  fp: 3,  sync: 6,   bp: 29,  pol: POL_LOW}
  };

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-enable and raster timing bundle between the generator and the pixel path
//
// Purpose: groups the pixel clock-enable and every timing output of
// vga_timing_gen so pixel pipelines take one port.
//   pix_ce           pixel enable, supplied by the pixel-rate source
//   vga_h_sync       horizontal sync at its configured polarity
//   vga_v_sync       vertical sync at its configured polarity
//   in_display_area  current (counter_x, counter_y) is visible
//   counter_x/y      current pixel column / line
//   line_start       one-clk strobe on the first pixel of every line
//   frame_start      one-clk strobe on the first pixel of every frame
// Modports: master = timing generator, slave = pixel path / enable source.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);

  logic             pix_ce;
  logic             vga_h_sync;
  logic             vga_v_sync;
  logic             in_display_area;
  logic [CNT_W-1:0] counter_x;
  logic [CNT_W-1:0] counter_y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pix_ce,
    output vga_h_sync,
    output vga_v_sync,
    output in_display_area,
    output counter_x,
    output counter_y,
    output line_start,
    output frame_start
  );

  modport slave (
    output pix_ce,
    input  vga_h_sync,
    input  vga_v_sync,
    input  in_display_area,
    input  counter_x,
    input  counter_y,
    input  line_start,
    input  frame_start
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// rtl/vga_timing_gen_axis_counter.sv - one raster axis: wrapping position counter with active and sync decode
//
// Purpose: counts positions 0..TOTAL-1 along one axis and decodes the
// visible region and sync window from the current count (combinational).
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   ce          pixel enable
//   inc         advance request for this axis (1 for horizontal, line wrap for vertical)
//   cnt         current position
//   wrap        cnt is at TOTAL-1 and this axis advances on the next enabled edge
//   active      cnt lies in the visible segment
//   sync        sync level, POL while cnt is in the sync segment, ~POL otherwise
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = POL_LOW,
  parameter int   CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL      = total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  if (TOTAL > 2 ** CNT_W) begin : g_total_check
    $error("vga_axis_counter: total %0d does not fit in %0d counter bits", TOTAL, CNT_W);
  end

  if (SYNC < 1) begin : g_sync_check
    $error("vga_axis_counter: sync width must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      cnt_w;
  logic             at_last;
  logic             in_sync;

  assign at_last = (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (ce && inc) begin
      cnt_q <= at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Decode in 32 bits so a sync window ending exactly at 2**CNT_W
  // (zero back porch, full-range counter) does not truncate to 0.
  assign cnt_w   = 32'(cnt_q);
  assign in_sync = (cnt_w >= 32'(SYNC_START)) && (cnt_w < 32'(SYNC_END));

  assign cnt    = cnt_q;
  assign wrap   = inc && at_last;
  assign active = (cnt_w < 32'(ACTIVE));
  assign sync   = in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pixel enable and line/frame strobes
//
// Purpose: drives syncs, display-area flag, pixel position and line/frame
// strobes for a raster of (H_ACTIVE+H_FP+H_SYNC+H_BP) x (V_ACTIVE+V_FP+V_SYNC+V_BP)
// enabled clocks. All outputs are registered from the same counter values,
// so they are mutually aligned, one enabled clk behind the counters.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   vid    vga_timing_gen_if.master: pix_ce in, timing outputs out
//          (interface CNT_W must equal this module's CNT_W)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W    = 10,
  parameter int   H_ACTIVE = MODE_640X480_60.h.active,
  parameter int   H_FP     = MODE_640X480_60.h.fp,
  parameter int   H_SYNC   = MODE_640X480_60.h.sync,
  parameter int   H_BP     = MODE_640X480_60.h.bp,
  parameter int   V_ACTIVE = MODE_640X480_60.v.active,
  parameter int   V_FP     = MODE_640X480_60.v.fp,
  parameter int   V_SYNC   = MODE_640X480_60.v.sync,
  parameter int   V_BP     = MODE_640X480_60.v.bp,
  parameter logic H_POL    = POL_LOW,
  parameter logic V_POL    = POL_LOW
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_gen_if.master   vid
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             h_active;
  logic             v_active;
  logic             h_sync_lvl;
  logic             v_sync_lvl;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .ce     (vid.pix_ce),
    .inc    (1'b1),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync_lvl)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .ce     (vid.pix_ce),
    .inc    (h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync_lvl)
  );

  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             de_q;
  logic             hs_q;
  logic             vs_q;
  logic             line_q;
  logic             frame_q;

  // Output stage. Reset leaves the syncs deasserted and the display flag
  // low; the first enabled edge afterwards presents pixel (0,0) together
  // with both strobes, so a full frame always follows reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (vid.pix_ce) begin
      x_q     <= h_cnt;
      y_q     <= v_cnt;
      de_q    <= h_active && v_active;
      hs_q    <= h_sync_lvl;
      vs_q    <= v_sync_lvl;
      line_q  <= (h_cnt == '0);
      frame_q <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Strobes last one clk even when pix_ce is slower than clk.
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end
  end

  assign vid.counter_x       = x_q;
  assign vid.counter_y       = y_q;
  assign vid.in_display_area = de_q;
  assign vid.vga_h_sync      = hs_q;
  assign vid.vga_v_sync      = vs_q;
  assign vid.line_start      = line_q;
  assign vid.frame_start     = frame_q;

endmodule
